// File: rtl/program_loader_if.sv
// Stream-in handshake and program-memory write port of the program loader.
interface program_loader_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) ();
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  mem_write;

    // Producer / memory side.
    modport master (
        output in_valid, in_data,
        input  in_ready, mem_addr, mem_data, mem_write
    );

    // Loader side.
    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_addr, mem_data, mem_write
    );
endinterface

// File: rtl/program_loader.sv
// Loads a length-prefixed, XOR-checksummed image into program memory and
// holds the control unit in reset until the image has been verified.
module program_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    program_loader_if.slave       bus,
    output logic                  cpu_reset_n,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CHECK,
        S_RUN,
        S_ERR
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic [ADDR_WIDTH-1:0] remaining_q, remaining_d;
    logic [DATA_WIDTH-1:0] xor_q, xor_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
    logic                  mem_write_q, mem_write_d;
    logic                  in_ready_q, in_ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic                  cpu_reset_n_q, cpu_reset_n_d;
    logic                  xfer;
    logic [ADDR_WIDTH-1:0] len_byte;

    assign xfer     = bus.in_valid && in_ready_q;
    assign len_byte = ADDR_WIDTH'(bus.in_data);

    // Next-state, datapath and output decode; outputs follow the next state
    // so every status line comes straight from a flop.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        remaining_d = remaining_q;
        xor_d       = xor_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        mem_write_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LEN;
            end
            S_LEN: begin
                if (xfer) begin
                    if (len_byte == '0) begin
                        state_d = S_ERR;
                    end else begin
                        state_d     = S_DATA;
                        count_d     = '0;
                        remaining_d = len_byte;
                        xor_d       = '0;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    mem_addr_d  = count_q;
                    mem_data_d  = bus.in_data;
                    mem_write_d = 1'b1;
                    count_d     = count_q + ADDR_WIDTH'(1);
                    remaining_d = remaining_q - ADDR_WIDTH'(1);
                    xor_d       = xor_q ^ bus.in_data;
                    if (remaining_q == ADDR_WIDTH'(1)) state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (xfer) state_d = (bus.in_data == xor_q) ? S_RUN : S_ERR;
            end
            S_RUN, S_ERR: begin
                if (start) state_d = S_LEN;
            end
            default: state_d = S_IDLE;
        endcase

        in_ready_d    = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CHECK);
        busy_d        = in_ready_d;
        done_d        = (state_d == S_RUN);
        cpu_reset_n_d = (state_d == S_RUN);
        error_d       = (state_d == S_ERR);
    end

    // State and registered outputs; reset drops any pending write and holds the CPU.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            count_q       <= '0;
            remaining_q   <= '0;
            xor_q         <= '0;
            mem_addr_q    <= '0;
            mem_data_q    <= '0;
            mem_write_q   <= 1'b0;
            in_ready_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            cpu_reset_n_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            remaining_q   <= remaining_d;
            xor_q         <= xor_d;
            mem_addr_q    <= mem_addr_d;
            mem_data_q    <= mem_data_d;
            mem_write_q   <= mem_write_d;
            in_ready_q    <= in_ready_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
            cpu_reset_n_q <= cpu_reset_n_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_data  = mem_data_q;
    assign bus.mem_write = mem_write_q;
    assign cpu_reset_n   = cpu_reset_n_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
endmodule
